// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync, display-enable, position and frame-start outputs (one cycle of latency).
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] hc, hc_next;
    logic [VW-1:0] vc, vc_next;
    logic          h_wrap;
    logic          hs_d, vs_d, blank_d, frame_start_d;

    always_comb begin
        h_wrap  = (hc == H_LAST);
        hc_next = h_wrap ? '0 : hc + HW'(1);
        vc_next = vc;
        if (h_wrap) begin
            vc_next = (vc == V_LAST) ? '0 : vc + VW'(1);
        end
    end

    // Decode from the current counters; the registers below align every output
    // to the same (hc,vc), so nothing downstream sees a mixed-position cycle.
    always_comb begin
        blank_d       = (int'(hc) < H_VISIBLE) && (int'(vc) < V_VISIBLE);
        hs_d          = !((int'(hc) >= H_VISIBLE + H_FP) &&
                          (int'(hc) <  H_VISIBLE + H_FP + H_SYNC));
        vs_d          = !((int'(vc) >= V_VISIBLE + V_FP) &&
                          (int'(vc) <  V_VISIBLE + V_FP + V_SYNC));
        frame_start_d = (hc == '0) && (vc == '0);
    end

    // NOTE: outputs sit in the async reset branch too, so a mid-frame reset
    // forces idle sync levels immediately instead of at the next pixel edge.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            DrawX       <= '0;
            DrawY       <= '0;
            frame_start <= 1'b0;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            hs          <= hs_d;
            vs          <= vs_d;
            blank       <= blank_d;
            DrawX       <= 10'(hc);
            DrawY       <= 10'(vc);
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing over the first lines plus a shrunken
// 8/2/2/2 x 4/1/1/1 instance run for three complete frames.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       a_hs, a_vs, a_blank, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_blank, b_fs;
    logic [9:0] b_x, b_y;

    int n_vec = 0;
    int n_err = 0;

    int ex, ey, guard;
    int pos_err, blank_fall, hs_fall, hs_run, hs_first_run, hs_low;
    int bad_vs, bad_fs, bad_blank;
    int pos_err_b, blank_cnt, vs_low, bad_hs_b, bad_vs_b, oob, bad_blank_b;
    int fs_q[$];
    logic prev_blank, prev_hs;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .vga_clk(clk), .reset(rst_a), .hs(a_hs), .vs(a_vs), .blank(a_blank),
        .DrawX(a_x), .DrawY(a_y), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_b (
        .vga_clk(clk), .reset(rst_b), .hs(b_hs), .vs(b_vs), .blank(b_blank),
        .DrawX(b_x), .DrawY(b_y), .frame_start(b_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string pfx);
        check({pfx, "_x"},     32'(a_x), 0);
        check({pfx, "_y"},     32'(a_y), 0);
        check({pfx, "_hs"},    32'(a_hs), 1);
        check({pfx, "_vs"},    32'(a_vs), 1);
        check({pfx, "_blank"}, 32'(a_blank), 0);
        check({pfx, "_fs"},    32'(a_fs), 0);
    endtask

    initial begin
        // Reset held across several clock edges.
        #23;
        check_reset_a("a_rst");
        check("b_rst_x",     32'(b_x), 0);
        check("b_rst_y",     32'(b_y), 0);
        check("b_rst_hs",    32'(b_hs), 1);
        check("b_rst_vs",    32'(b_vs), 1);
        check("b_rst_blank", 32'(b_blank), 0);
        check("b_rst_fs",    32'(b_fs), 0);

        // First edge after release shows pixel (0,0) as a frame start.
        @(negedge clk) rst_a = 1'b0;
        step;
        check("a_first_x",     32'(a_x), 0);
        check("a_first_y",     32'(a_y), 0);
        check("a_first_blank", 32'(a_blank), 1);
        check("a_first_fs",    32'(a_fs), 1);
        check("a_first_hs",    32'(a_hs), 1);
        check("a_first_vs",    32'(a_vs), 1);
        step;
        check("a_second_x",  32'(a_x), 1);
        check("a_second_fs", 32'(a_fs), 0);

        // Two full lines of the default timing; sample k shows hc = k-1.
        pos_err = 0; blank_fall = -1; hs_fall = -1; hs_run = 0; hs_first_run = -1;
        hs_low = 0; bad_vs = 0; bad_fs = 0; bad_blank = 0;
        prev_blank = a_blank; prev_hs = a_hs;
        for (int k = 3; k <= 1602; k++) begin
            step;
            ex = (k - 1) % 800;
            ey = (k - 1) / 800;
            if (int'(a_x) != ex || int'(a_y) != ey) pos_err++;
            if (prev_blank && !a_blank && blank_fall < 0) blank_fall = int'(a_x);
            if (prev_hs && !a_hs && hs_fall < 0) hs_fall = int'(a_x);
            if (!a_hs) begin
                hs_low++;
                hs_run++;
            end else if (hs_run > 0) begin
                if (hs_first_run < 0) hs_first_run = hs_run;
                hs_run = 0;
            end
            if (a_vs !== 1'b1) bad_vs++;
            if (a_fs !== 1'b0) bad_fs++;
            if (a_blank !== (ex < 640)) bad_blank++;
            if (k == 800) begin
                check("a_line_end_x", 32'(a_x), 799);
                check("a_line_end_y", 32'(a_y), 0);
            end
            if (k == 801) begin
                check("a_line_wrap_x", 32'(a_x), 0);
                check("a_line_wrap_y", 32'(a_y), 1);
            end
            prev_blank = a_blank;
            prev_hs = a_hs;
        end
        check("a_pos_track",    32'(pos_err), 0);
        check("a_blank_fall_x", 32'(blank_fall), 640);
        check("a_hs_fall_x",    32'(hs_fall), 656);
        check("a_hs_run_len",   32'(hs_first_run), 96);
        check("a_hs_low_total", 32'(hs_low), 192);
        check("a_vs_idle",      32'(bad_vs), 0);
        check("a_fs_quiet",     32'(bad_fs), 0);
        check("a_blank_region", 32'(bad_blank), 0);

        // Asynchronous reset in mid-frame, between clock edges.
        guard = 0;
        while (!(a_x == 10'd300 && a_y == 10'd2) && guard < 1000) begin
            step;
            guard++;
        end
        check("a_reach_x", 32'(a_x), 300);
        check("a_reach_y", 32'(a_y), 2);
        #2 rst_a = 1'b1;
        #1;
        check_reset_a("a_async");
        step;
        step;
        check_reset_a("a_held");
        @(negedge clk) rst_a = 1'b0;
        step;
        check("a_rel_x",     32'(a_x), 0);
        check("a_rel_y",     32'(a_y), 0);
        check("a_rel_blank", 32'(a_blank), 1);
        check("a_rel_fs",    32'(a_fs), 1);
        step;
        check("a_rel2_x",  32'(a_x), 1);
        check("a_rel2_fs", 32'(a_fs), 0);

        // Shrunken timing: 14 x 7 = 98-cycle frame, three frames.
        pos_err_b = 0; blank_cnt = 0; vs_low = 0; bad_hs_b = 0; bad_vs_b = 0;
        oob = 0; bad_blank_b = 0;
        @(negedge clk) rst_b = 1'b0;
        for (int k = 1; k <= 294; k++) begin
            step;
            ex = (k - 1) % 14;
            ey = ((k - 1) / 14) % 7;
            if (int'(b_x) != ex || int'(b_y) != ey) pos_err_b++;
            if (b_fs === 1'b1) fs_q.push_back(k);
            if (b_blank === 1'b1) blank_cnt++;
            if (b_hs !== !(ex == 10 || ex == 11)) bad_hs_b++;
            if (b_vs !== (ey != 5)) bad_vs_b++;
            if (b_vs === 1'b0) vs_low++;
            if (b_x > 10'd13 || b_y > 10'd6) oob++;
            if (b_blank && !(b_x < 10'd8 && b_y < 10'd4)) bad_blank_b++;
            if (k == 98) begin
                check("b_frame_end_x", 32'(b_x), 13);
                check("b_frame_end_y", 32'(b_y), 6);
            end
            if (k == 99) begin
                check("b_frame_wrap_x",  32'(b_x), 0);
                check("b_frame_wrap_y",  32'(b_y), 0);
                check("b_frame_wrap_fs", 32'(b_fs), 1);
            end
        end
        check("b_pos_track",   32'(pos_err_b), 0);
        check("b_fs_count",    32'(fs_q.size()), 3);
        if (fs_q.size() == 3) begin
            check("b_fs_at_0", 32'(fs_q[0]), 1);
            check("b_fs_at_1", 32'(fs_q[1]), 99);
            check("b_fs_at_2", 32'(fs_q[2]), 197);
        end
        check("b_blank_count", 32'(blank_cnt), 96);
        check("b_vs_low",      32'(vs_low), 42);
        check("b_hs_decode",   32'(bad_hs_b), 0);
        check("b_vs_decode",   32'(bad_vs_b), 0);
        check("b_out_of_range", 32'(oob), 0);
        check("b_blank_region", 32'(bad_blank_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
